// File: rtl/fifo_2c_pop_reader.sv
// Destination-domain reader for the dual-clock FIFO pop port: drains words into a
// 2-entry skid buffer, presents them as a valid/ready stream and sequences clears.
module fifo_2c_pop_reader #(
  parameter int width       = 8,
  parameter int cnt_width   = 16,
  parameter int clr_timeout = 255
) (
  input  logic                 clk_d,
  input  logic                 rst_d,
  input  logic                 init_d,
  input  logic                 fifo_empty_d,
  input  logic [width-1:0]     fifo_data_d,
  input  logic                 fifo_error_d,
  input  logic                 fifo_clr_in_prog_d,
  input  logic                 fifo_clr_cmplt_d,
  output logic                 fifo_pop_d_n,
  output logic                 fifo_clr_d,
  output logic                 m_valid,
  output logic [width-1:0]     m_data,
  input  logic                 m_ready,
  input  logic                 clr_req,
  output logic                 clr_busy,
  output logic                 clr_done,
  output logic [cnt_width-1:0] pop_cnt,
  input  logic                 err_clr,
  output logic                 err_sticky,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    CLR_ASSERT = 2'd1,
    CLR_WAIT   = 2'd2
  } state_t;

  localparam logic [16:0] TMO_LIM = 17'(clr_timeout);

  state_t           state, state_nxt;
  logic [1:0]       occ;
  logic [width-1:0] buf0, buf1;
  logic [15:0]      tmo_cnt;
  logic [16:0]      tmo_inc;
  logic             pop, consume, timeout_hit, cmplt_hit;

  // Stream handshake: a word transfers on any rising edge where m_valid && m_ready;
  // m_valid never depends on m_ready and m_data is stable while m_valid && !m_ready.
  assign m_valid   = (occ != 2'd0);
  assign m_data    = buf0;
  assign consume   = m_valid && m_ready;
  assign clr_busy  = (state != RUN);
  assign dbg_state = state;
  assign tmo_inc   = {1'b0, tmo_cnt} + 17'd1;

  // Pop looks only at registered state and FIFO status so m_ready never reaches pop_d_n.
  assign pop = (state == RUN) && !clr_req && !fifo_empty_d && !fifo_clr_in_prog_d &&
               (occ != 2'd2) && !init_d;
  assign fifo_pop_d_n = rst_d || !pop;

  always_comb begin
    state_nxt   = state;
    fifo_clr_d  = 1'b0;
    timeout_hit = 1'b0;
    cmplt_hit   = 1'b0;
    case (state)
      RUN: begin
        if (clr_req) state_nxt = CLR_ASSERT;
      end
      CLR_ASSERT: begin
        fifo_clr_d = 1'b1;
        state_nxt  = CLR_WAIT;
      end
      CLR_WAIT: begin
        if (fifo_clr_cmplt_d) begin
          cmplt_hit = 1'b1;
          state_nxt = RUN;
        end else if (tmo_inc >= TMO_LIM) begin
          timeout_hit = 1'b1;
          state_nxt   = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk_d or posedge rst_d) begin
    if (rst_d) begin
      state      <= RUN;
      occ        <= 2'd0;
      buf0       <= '0;
      buf1       <= '0;
      tmo_cnt    <= '0;
      clr_done   <= 1'b0;
      pop_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (init_d) begin
      state      <= RUN;
      occ        <= 2'd0;
      buf0       <= '0;
      buf1       <= '0;
      tmo_cnt    <= '0;
      clr_done   <= 1'b0;
      pop_cnt    <= '0;
      err_sticky <= 1'b0;
    end else begin
      state    <= state_nxt;
      clr_done <= cmplt_hit;

      if (state == RUN && state_nxt == CLR_ASSERT) tmo_cnt <= '0;
      else if (state == CLR_WAIT) tmo_cnt <= tmo_cnt + 16'd1;

      if (fifo_error_d || timeout_hit) err_sticky <= 1'b1;
      else if (err_clr) err_sticky <= 1'b0;

      if (cmplt_hit) pop_cnt <= '0;
      else if (pop) pop_cnt <= pop_cnt + cnt_width'(1);

      // The flush overrides any handshake that happens in the same cycle.
      if (state == CLR_ASSERT) begin
        occ  <= 2'd0;
        buf0 <= '0;
        buf1 <= '0;
      end else begin
        case ({pop, consume})
          2'b10: begin
            if (occ == 2'd0) buf0 <= fifo_data_d;
            else buf1 <= fifo_data_d;
            occ <= occ + 2'd1;
          end
          2'b01: begin
            if (occ == 2'd2) buf0 <= buf1;
            occ <= occ - 2'd1;
          end
          2'b11: buf0 <= fifo_data_d;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_2c_pop_reader.sv
// Directed bench for fifo_2c_pop_reader: a small FIFO model feeds the pop port and
// each task checks one behaviour cycle by cycle against hand-computed values.
module tb_fifo_2c_pop_reader;

  logic        clk = 1'b0;
  logic        rst_d, init_d;
  logic        fifo_empty_d, fifo_error_d, fifo_clr_in_prog_d, fifo_clr_cmplt_d;
  logic [7:0]  fifo_data_d;
  logic        fifo_pop_d_n, fifo_clr_d, m_valid, m_ready, clr_req, clr_busy, clr_done;
  logic [7:0]  m_data;
  logic [15:0] pop_cnt;
  logic        err_clr, err_sticky;
  logic [1:0]  dbg_state;

  logic        t_pop_d_n, t_clr_d, t_m_valid, t_clr_req, t_clr_busy, t_clr_done, t_err_sticky;
  logic [7:0]  t_m_data;
  logic [15:0] t_pop_cnt;
  logic [1:0]  t_dbg_state;

  logic [7:0]  fifo_mem [0:31];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        tb_flush;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  assign fifo_empty_d = (rd_ptr == wr_ptr);
  assign fifo_data_d  = fifo_mem[rd_ptr[4:0]];

  always @(posedge clk) begin
    if (tb_flush) rd_ptr <= wr_ptr;
    else if (!fifo_pop_d_n && rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;
  end

  fifo_2c_pop_reader #(.width(8), .cnt_width(16), .clr_timeout(255)) dut (
    .clk_d(clk), .rst_d(rst_d), .init_d(init_d),
    .fifo_empty_d(fifo_empty_d), .fifo_data_d(fifo_data_d), .fifo_error_d(fifo_error_d),
    .fifo_clr_in_prog_d(fifo_clr_in_prog_d), .fifo_clr_cmplt_d(fifo_clr_cmplt_d),
    .fifo_pop_d_n(fifo_pop_d_n), .fifo_clr_d(fifo_clr_d),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done), .pop_cnt(pop_cnt),
    .err_clr(err_clr), .err_sticky(err_sticky), .dbg_state(dbg_state)
  );

  fifo_2c_pop_reader #(.width(8), .cnt_width(16), .clr_timeout(4)) dut_t (
    .clk_d(clk), .rst_d(rst_d), .init_d(1'b0),
    .fifo_empty_d(1'b1), .fifo_data_d(8'h00), .fifo_error_d(1'b0),
    .fifo_clr_in_prog_d(1'b0), .fifo_clr_cmplt_d(1'b0),
    .fifo_pop_d_n(t_pop_d_n), .fifo_clr_d(t_clr_d),
    .m_valid(t_m_valid), .m_data(t_m_data), .m_ready(1'b1),
    .clr_req(t_clr_req), .clr_busy(t_clr_busy), .clr_done(t_clr_done), .pop_cnt(t_pop_cnt),
    .err_clr(1'b0), .err_sticky(t_err_sticky), .dbg_state(t_dbg_state)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    fifo_mem[wr_ptr[4:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic test_reset;
    push(8'h11); push(8'h22); push(8'h33);
    tick; tick;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", m_valid); end
    total++; if (m_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", m_data); end
    total++; if (fifo_pop_d_n !== 1'b1) begin bad++; $display("FAIL rst_pop_n got=%b want=1", fifo_pop_d_n); end
    total++; if (fifo_clr_d !== 1'b0) begin bad++; $display("FAIL rst_clr_d got=%b want=0", fifo_clr_d); end
    total++; if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin bad++; $display("FAIL rst_clr got=%b%b want=00", clr_busy, clr_done); end
    total++; if (pop_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", pop_cnt); end
    total++; if (err_sticky !== 1'b0 || t_err_sticky !== 1'b0) begin bad++; $display("FAIL rst_err got=%b%b want=00", err_sticky, t_err_sticky); end
  endtask

  task automatic test_stream;
    m_ready = 1'b1;
    rst_d = 1'b0;
    #1;
    total++; if (fifo_pop_d_n !== 1'b0) begin bad++; $display("FAIL str_pop0 got=%b want=0", fifo_pop_d_n); end
    tick;
    total++; if (m_valid !== 1'b1 || m_data !== 8'h11) begin bad++; $display("FAIL str_w0 got=%b/%h want=1/11", m_valid, m_data); end
    total++; if (fifo_pop_d_n !== 1'b0) begin bad++; $display("FAIL str_pop1 got=%b want=0", fifo_pop_d_n); end
    tick;
    total++; if (m_valid !== 1'b1 || m_data !== 8'h22) begin bad++; $display("FAIL str_w1 got=%b/%h want=1/22", m_valid, m_data); end
    total++; if (fifo_pop_d_n !== 1'b0) begin bad++; $display("FAIL str_pop2 got=%b want=0", fifo_pop_d_n); end
    tick;
    total++; if (m_valid !== 1'b1 || m_data !== 8'h33) begin bad++; $display("FAIL str_w2 got=%b/%h want=1/33", m_valid, m_data); end
    total++; if (fifo_pop_d_n !== 1'b1) begin bad++; $display("FAIL str_pop3 got=%b want=1", fifo_pop_d_n); end
    total++; if (pop_cnt !== 16'd3) begin bad++; $display("FAIL str_cnt got=%0d want=3", pop_cnt); end
    tick;
    total++; if (m_valid !== 1'b0 || m_data !== 8'h33) begin bad++; $display("FAIL str_idle got=%b/%h want=0/33", m_valid, m_data); end
  endtask

  task automatic test_backpressure;
    logic [7:0] exp_d [0:3];
    exp_d[0] = 8'h42; exp_d[1] = 8'h43; exp_d[2] = 8'h44; exp_d[3] = 8'h44;
    m_ready = 1'b0;
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    #1;
    total++; if (fifo_pop_d_n !== 1'b0) begin bad++; $display("FAIL bp_pop0 got=%b want=0", fifo_pop_d_n); end
    tick;
    total++; if (m_data !== 8'h41 || fifo_pop_d_n !== 1'b0) begin bad++; $display("FAIL bp_c1 got=%h/%b want=41/0", m_data, fifo_pop_d_n); end
    for (int i = 0; i < 2; i++) begin
      tick;
      total++; if (m_valid !== 1'b1 || m_data !== 8'h41 || fifo_pop_d_n !== 1'b1) begin bad++; $display("FAIL bp_hold%0d got=%b/%h/%b want=1/41/1", i, m_valid, m_data, fifo_pop_d_n); end
    end
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if (m_valid !== 1'b1 || m_data !== exp_d[i]) begin bad++; $display("FAIL bp_drain%0d got=%b/%h want=1/%h", i, m_valid, m_data, exp_d[i]); end
    end
    tick;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", m_valid); end
    total++; if (pop_cnt !== 16'd7) begin bad++; $display("FAIL bp_cnt got=%0d want=7", pop_cnt); end
  endtask

  task automatic test_clear;
    int busy_cycles;
    int done_pulses;
    m_ready = 1'b0;
    push(8'h51); push(8'h52); push(8'h53);
    tick; tick;
    total++; if (m_valid !== 1'b1 || fifo_pop_d_n !== 1'b1) begin bad++; $display("FAIL clr_full got=%b/%b want=1/1", m_valid, fifo_pop_d_n); end
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    m_ready = 1'b1;
    #1;
    busy_cycles = 0;
    done_pulses = 0;
    total++; if (fifo_clr_d !== 1'b1 || m_data !== 8'h51 || fifo_pop_d_n !== 1'b1) begin bad++; $display("FAIL clr_assert got=%b/%h/%b want=1/51/1", fifo_clr_d, m_data, fifo_pop_d_n); end
    for (int c = 0; c < 6; c++) begin
      if (clr_busy === 1'b1) busy_cycles++;
      if (clr_done === 1'b1) done_pulses++;
      if (c == 1) begin
        total++; if (m_valid !== 1'b0 || m_data !== 8'h00 || fifo_clr_d !== 1'b0) begin bad++; $display("FAIL clr_flush got=%b/%h/%b want=0/00/0", m_valid, m_data, fifo_clr_d); end
        total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL clr_state got=%0d want=2", dbg_state); end
      end
      if (c > 0) begin
        total++; if (fifo_pop_d_n !== 1'b1) begin bad++; $display("FAIL clr_nopop%0d got=%b want=1", c, fifo_pop_d_n); end
      end
      clr_req = (c == 2);
      fifo_clr_cmplt_d = (c == 5);
      tb_flush = (c == 5);
      tick;
    end
    fifo_clr_cmplt_d = 1'b0;
    tb_flush = 1'b0;
    clr_req = 1'b0;
    total++; if (busy_cycles != 6 || done_pulses != 0) begin bad++; $display("FAIL clr_busy_len got=%0d/%0d want=6/0", busy_cycles, done_pulses); end
    total++; if (clr_done !== 1'b1 || clr_busy !== 1'b0) begin bad++; $display("FAIL clr_done got=%b/%b want=1/0", clr_done, clr_busy); end
    total++; if (pop_cnt !== 16'd0) begin bad++; $display("FAIL clr_cnt got=%0d want=0", pop_cnt); end
    tick;
    total++; if (clr_done !== 1'b0 || clr_busy !== 1'b0) begin bad++; $display("FAIL clr_after got=%b/%b want=0/0", clr_done, clr_busy); end
  endtask

  task automatic test_timeout;
    t_clr_req = 1'b1;
    tick;
    t_clr_req = 1'b0;
    total++; if (t_clr_d !== 1'b1 || t_clr_busy !== 1'b1) begin bad++; $display("FAIL tmo_assert got=%b/%b want=1/1", t_clr_d, t_clr_busy); end
    for (int c = 0; c < 4; c++) begin
      tick;
      total++; if (t_clr_busy !== 1'b1 || t_err_sticky !== 1'b0 || t_clr_done !== 1'b0) begin bad++; $display("FAIL tmo_wait%0d got=%b/%b/%b want=1/0/0", c, t_clr_busy, t_err_sticky, t_clr_done); end
    end
    tick;
    total++; if (t_clr_busy !== 1'b0 || t_err_sticky !== 1'b1) begin bad++; $display("FAIL tmo_exit got=%b/%b want=0/1", t_clr_busy, t_err_sticky); end
    total++; if (t_clr_done !== 1'b0) begin bad++; $display("FAIL tmo_done got=%b want=0", t_clr_done); end
    tick;
    total++; if (t_clr_done !== 1'b0 || t_clr_busy !== 1'b0) begin bad++; $display("FAIL tmo_after got=%b/%b want=0/0", t_clr_done, t_clr_busy); end
  endtask

  task automatic test_error;
    fifo_error_d = 1'b1; err_clr = 1'b1;
    tick;
    total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL err_prio got=%b want=1", err_sticky); end
    fifo_error_d = 1'b0;
    tick;
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL err_clr got=%b want=0", err_sticky); end
    err_clr = 1'b0; fifo_error_d = 1'b1;
    tick;
    fifo_error_d = 1'b0;
    tick;
    total++; if (err_sticky !== 1'b1) begin bad++; $display("FAIL err_hold got=%b want=1", err_sticky); end
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL err_clr2 got=%b want=0", err_sticky); end
  endtask

  task automatic test_src_clear;
    m_ready = 1'b0;
    push(8'h61); push(8'h62);
    tick;
    fifo_clr_in_prog_d = 1'b1;
    #1;
    total++; if (fifo_pop_d_n !== 1'b1 || clr_busy !== 1'b0) begin bad++; $display("FAIL src_block got=%b/%b want=1/0", fifo_pop_d_n, clr_busy); end
    tick;
    total++; if (m_valid !== 1'b1 || m_data !== 8'h61) begin bad++; $display("FAIL src_keep got=%b/%h want=1/61", m_valid, m_data); end
    m_ready = 1'b1;
    tick;
    total++; if (m_valid !== 1'b0 || fifo_pop_d_n !== 1'b1) begin bad++; $display("FAIL src_drain got=%b/%b want=0/1", m_valid, fifo_pop_d_n); end
    fifo_clr_in_prog_d = 1'b0;
    #1;
    total++; if (fifo_pop_d_n !== 1'b0) begin bad++; $display("FAIL src_resume got=%b want=0", fifo_pop_d_n); end
    tick;
    total++; if (m_valid !== 1'b1 || m_data !== 8'h62) begin bad++; $display("FAIL src_w got=%b/%h want=1/62", m_valid, m_data); end
    tick;
    total++; if (m_valid !== 1'b0 || pop_cnt !== 16'd2) begin bad++; $display("FAIL src_cnt got=%b/%0d want=0/2", m_valid, pop_cnt); end
  endtask

  task automatic test_rst_midstream;
    m_ready = 1'b0;
    push(8'h71); push(8'h72);
    tick;
    total++; if (m_valid !== 1'b1 || fifo_pop_d_n !== 1'b0) begin bad++; $display("FAIL mrst_pre got=%b/%b want=1/0", m_valid, fifo_pop_d_n); end
    rst_d = 1'b1;
    #1;
    total++; if (m_valid !== 1'b0 || fifo_pop_d_n !== 1'b1 || pop_cnt !== 16'd0) begin bad++; $display("FAIL mrst_async got=%b/%b/%0d want=0/1/0", m_valid, fifo_pop_d_n, pop_cnt); end
    tick;
    rst_d = 1'b0;
    tick;
    total++; if (m_data !== 8'h72 || pop_cnt !== 16'd1) begin bad++; $display("FAIL mrst_resume got=%h/%0d want=72/1", m_data, pop_cnt); end
    init_d = 1'b1;
    tick;
    init_d = 1'b0;
    total++; if (m_valid !== 1'b0 || pop_cnt !== 16'd0 || m_data !== 8'h00) begin bad++; $display("FAIL init got=%b/%0d/%h want=0/0/00", m_valid, pop_cnt, m_data); end
  endtask

  initial begin
    rst_d = 1'b1; init_d = 1'b0;
    fifo_error_d = 1'b0; fifo_clr_in_prog_d = 1'b0; fifo_clr_cmplt_d = 1'b0;
    m_ready = 1'b0; clr_req = 1'b0; err_clr = 1'b0; t_clr_req = 1'b0; tb_flush = 1'b0;
    test_reset;
    test_stream;
    test_backpressure;
    test_clear;
    test_timeout;
    test_error;
    test_src_clear;
    test_rst_midstream;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/fifo_2c_pop_reader.md
Name: fifo_2c_pop_reader

Overview:
- Destination-domain reader for the dual-clock FIFO's pop interface.
- Drains words from the FIFO destination port (pop_d_n, data_d, empty_d, error_d, clr handshake) into a 2-entry skid buffer.
- Presents the words as a valid/ready stream.
- Sequences destination-initiated FIFO clears, and keeps a pop counter and a sticky error flag for the control/status block.

Parameters:
- width, 8, data word width; must match the FIFO width.
- cnt_width, 16, width of the pop counter.
- clr_timeout, 255, maximum cycles to wait in CLR_WAIT for clr_cmplt; range 1..65535.

Ports:
- clk_d  in  1  destination-domain clock; all logic on its rising edge.
- rst_d  in  1  asynchronous active-high reset.
- init_d  in  1  synchronous active-high soft reset; same effect as rst_d.
- fifo_empty_d  in  1  FIFO empty_d.
- fifo_data_d  in  width  FIFO data_d; show-ahead, valid when fifo_empty_d=0.
- fifo_error_d  in  1  FIFO error_d.
- fifo_clr_in_prog_d  in  1  FIFO clr_in_prog_d.
- fifo_clr_cmplt_d  in  1  FIFO clr_cmplt_d.
- fifo_pop_d_n  out  1  FIFO pop_d_n, active low.
- fifo_clr_d  out  1  FIFO clr_d request.
- m_valid  out  1  output stream valid.
- m_data  out  width  output stream data.
- m_ready  in  1  output stream ready.
- clr_req  in  1  clear request pulse.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse on clear completion.
- pop_cnt  out  cnt_width  words popped since reset or last clear.
- err_clr  in  1  clears err_sticky.
- err_sticky  out  1  sticky error flag.

Behaviour:
- Reset (rst_d or init_d):
  - state=RUN, occ=0, buffer entries=0.
  - m_valid=0, m_data=0, fifo_pop_d_n=1, fifo_clr_d=0.
  - clr_busy=0, clr_done=0, pop_cnt=0, err_sticky=0, timeout counter=0.
  - fifo_pop_d_n is forced to 1 while rst_d is asserted.
- Skid buffer: 2 entries, occupancy occ in 0..2.
  - m_valid = (occ!=0); m_data = head entry. m_data is a registered value with no combinational path from fifo_data_d.
  - When occ=0, m_data holds its last value.
- Pop condition (combinational, from registers and FIFO status only; never from m_ready):
  - pop = state==RUN && !clr_req && !fifo_empty_d && !fifo_clr_in_prog_d && occ<2.
  - fifo_pop_d_n = !pop.
  - fifo_data_d is written into the tail entry on the same edge.
- Latency: a word at the FIFO head with occ<2 in cycle N is popped at the end of cycle N and appears as m_valid=1 in cycle N+1.
- Throughput: 1 word/cycle sustained when m_ready=1.
- Output handshake: a word is consumed when m_valid && m_ready.
  - Simultaneous pop and consume: occ unchanged, FIFO order preserved.
  - Data must not change while m_valid=1 and m_ready=0.
- pop_cnt increments by 1 per pop and wraps modulo 2^cnt_width.
- State machine:
  - RUN: clr_req=1 goes to CLR_ASSERT. clr_req outside RUN is ignored.
  - CLR_ASSERT (1 cycle):
    - fifo_clr_d=1, no pop.
    - Skid buffer flushed (occ becomes 0, entries become 0) at the end of the cycle.
    - A handshake in this cycle is allowed; the flush still wins.
    - Next state is CLR_WAIT.
  - CLR_WAIT:
    - fifo_clr_d=0, no pop, timeout counter increments each cycle.
    - fifo_clr_cmplt_d=1 goes to RUN: pop_cnt=0, clr_done=1 in the first RUN cycle.
    - Counter reaching clr_timeout without cmplt goes to RUN: err_sticky set, clr_done not pulsed.
- clr_busy = (state != RUN).
- Timeout counter is cleared on entry to CLR_ASSERT.
- err_sticky:
  - Set on fifo_error_d=1 in any cycle, or on clear timeout.
  - Cleared by err_clr=1; set has priority over clear in the same cycle.
- A FIFO clear started by the source side (fifo_clr_in_prog_d=1 while in RUN):
  - Pops are suppressed for its duration.
  - Buffered words remain deliverable.
  - No state change.

Test Plan:
- Reset then FIFO non-empty with words 0x11,0x22,0x33 and m_ready=1 → pop_d_n low for 3 consecutive cycles starting the cycle after reset release; m_data 0x11,0x22,0x33 on consecutive cycles starting 1 cycle after the first pop; pop_cnt=3.
- m_ready=0 with 4 words in the FIFO → exactly 2 pops, then pop_d_n=1; m_valid=1 and m_data=first word held stable; releasing m_ready delivers all 4 in order.
- clr_req with occ=2, then clr_cmplt_d asserted 5 cycles later → clr_d high for exactly 1 cycle; m_valid=0 the next cycle; clr_busy=1 for 6 cycles; clr_done pulse once; pop_cnt=0; no pops during the clear.
- clr_timeout=4, clr_cmplt_d never asserted → return to RUN after 4 CLR_WAIT cycles; err_sticky=1; clr_done stays 0.
- fifo_error_d pulsed in the same cycle as err_clr → err_sticky=1; err_clr alone next cycle → err_sticky=0.
- rst_d asserted mid-stream with occ=1 → m_valid, pop_d_n=1 and pop_cnt take reset values immediately (asynchronously); clr_req while in CLR_WAIT is ignored.
